// File: rtl/ov7670_pkg.sv
// ov7670_pkg: shared FSM state type, default frame geometry and pixel width
package ov7670_pkg;
  typedef enum logic [1:0] {IDLE, VBLANK, ACTIVE} state_t;
  localparam int H_DEF = 640;
  localparam int V_DEF = 480;
  localparam int PIX_W = 16;
endpackage

// File: rtl/ov7670_if.sv
// ov7670_if: camera byte stream in, assembled pixels and frame events out
interface ov7670_if #(
  parameter int H_PIXELS = ov7670_pkg::H_DEF,
  parameter int V_LINES  = ov7670_pkg::V_DEF
);
  logic                         href;
  logic                         vsync;
  logic [7:0]                   camData;
  logic [ov7670_pkg::PIX_W-1:0] pixelData;
  logic                         pixelValid;
  logic [$clog2(H_PIXELS)-1:0]  pixelX;
  logic [$clog2(V_LINES)-1:0]   pixelY;
  logic                         frameStart;
  logic                         frameDone;
  logic                         frameError;
  modport master (
    output href, vsync, camData,
    input  pixelData, pixelValid, pixelX, pixelY, frameStart, frameDone, frameError
  );
  modport slave (
    input  href, vsync, camData,
    output pixelData, pixelValid, pixelX, pixelY, frameStart, frameDone, frameError
  );
endinterface

// File: rtl/ov7670_pixel_assembler.sv
// ov7670_pixel_assembler: pairs bytes into RGB565 pixels, high byte first
module ov7670_pixel_assembler
  import ov7670_pkg::*;
(
  input  logic             pclk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [7:0]       data,
  output logic             done,
  output logic             odd,
  output logic [PIX_W-1:0] pix
);
  logic       phase;
  logic [7:0] hi;
  assign done = en & phase;
  assign odd  = phase;
  assign pix  = {hi, data};
  // phase toggles per qualified byte; the first byte of a pair is held
  always_ff @(posedge pclk) begin
    if (reset) begin
      phase <= 1'b0;
      hi    <= '0;
    end else begin
      phase <= clr ? 1'b0 : en ? ~phase : phase;
      if (en & ~phase) hi <= data;
    end
  end
endmodule

// File: rtl/ov7670_capture.sv
// ov7670_capture: OV7670 frame/line decoder producing coordinate-tagged pixels
module ov7670_capture
  import ov7670_pkg::*;
#(
  parameter int H_PIXELS = H_DEF,
  parameter int V_LINES  = V_DEF
) (
  input logic       pclk,
  input logic       reset,
  ov7670_if.slave   cam
);
  localparam int XW = $clog2(H_PIXELS);
  localparam int YW = $clog2(V_LINES);
  localparam logic [XW:0] H_MAX = H_PIXELS[XW:0];
  localparam logic [YW:0] V_MAX = V_LINES[YW:0];
  state_t           st;
  logic             href_s1, vsync_s1, href_q, vsync_q;
  logic [7:0]       data_s1;
  logic [XW:0]      col_cnt, col_nx;
  logic [YW:0]      line_cnt, line_nx;
  logic             got_pix, err, err_nx;
  logic             fall_h, v_fall, v_rise, keep, pix_done, odd;
  logic [PIX_W-1:0] pix;
  ov7670_pixel_assembler u_asm (
    .pclk  (pclk),
    .reset (reset),
    .en    (st == ACTIVE && href_s1),
    .clr   (st != ACTIVE || fall_h),
    .data  (data_s1),
    .done  (pix_done),
    .odd   (odd),
    .pix   (pix)
  );
  // edges, pixel acceptance and the same-cycle line/error updates feeding frameDone
  always_comb begin
    fall_h  = href_q & ~href_s1;
    v_fall  = vsync_q & ~vsync_s1;
    v_rise  = ~vsync_q & vsync_s1;
    keep    = pix_done && col_cnt < H_MAX && line_cnt < V_MAX;
    col_nx  = fall_h ? '0 : keep ? col_cnt + 1'b1 : col_cnt;
    line_nx = (fall_h && got_pix && line_cnt < V_MAX) ? line_cnt + 1'b1 : line_cnt;
    err_nx  = err | (pix_done & ~keep) | (fall_h & odd);
  end
  // input stage, frame FSM, counters and registered outputs
  always_ff @(posedge pclk) begin
    if (reset) begin
      st             <= IDLE;
      href_s1        <= 1'b0;
      vsync_s1       <= 1'b0;
      data_s1        <= '0;
      href_q         <= 1'b0;
      vsync_q        <= 1'b0;
      col_cnt        <= '0;
      line_cnt       <= '0;
      got_pix        <= 1'b0;
      err            <= 1'b0;
      cam.pixelData  <= '0;
      cam.pixelValid <= 1'b0;
      cam.pixelX     <= '0;
      cam.pixelY     <= '0;
      cam.frameStart <= 1'b0;
      cam.frameDone  <= 1'b0;
      cam.frameError <= 1'b0;
    end else begin
      href_s1        <= cam.href;
      vsync_s1       <= cam.vsync;
      data_s1        <= cam.camData;
      href_q         <= href_s1;
      vsync_q        <= vsync_s1;
      cam.pixelValid <= 1'b0;
      cam.frameStart <= 1'b0;
      cam.frameDone  <= 1'b0;
      cam.frameError <= 1'b0;
      case (st)
        IDLE: if (vsync_s1) st <= VBLANK;
        VBLANK: if (v_fall) begin
          st             <= ACTIVE;
          cam.frameStart <= 1'b1;
          col_cnt        <= '0;
          line_cnt       <= '0;
          got_pix        <= 1'b0;
          err            <= 1'b0;
        end
        ACTIVE: begin
          if (keep) begin
            cam.pixelValid <= 1'b1;
            cam.pixelData  <= pix;
            cam.pixelX     <= col_cnt[XW-1:0];
            cam.pixelY     <= line_cnt[YW-1:0];
          end
          col_cnt  <= col_nx;
          line_cnt <= line_nx;
          err      <= err_nx;
          got_pix  <= fall_h ? 1'b0 : got_pix | pix_done;
          if (v_rise) begin
            st             <= VBLANK;
            cam.frameDone  <= 1'b1;
            cam.frameError <= (line_nx != V_MAX) | err_nx;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ov7670_capture.sv
// tb_ov7670_capture: directed frames with hand-computed pixel and frame expectations
module tb_ov7670_capture;
  typedef struct {int d; int x; int y; int c;} pix_t;
  logic pclk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   starts = 0;
  int   n0;
  pix_t pq[$];
  logic dq[$];
  ov7670_if #(.H_PIXELS(4), .V_LINES(2)) bus ();
  ov7670_capture #(.H_PIXELS(4), .V_LINES(2)) dut (
    .pclk  (pclk),
    .reset (reset),
    .cam   (bus)
  );
  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;
  // record every output event half a cycle after the edge that produced it
  always @(negedge pclk) begin
    if (bus.pixelValid) pq.push_back('{int'(bus.pixelData), int'(bus.pixelX), int'(bus.pixelY), cyc});
    if (bus.frameDone) dq.push_back(bus.frameError);
    if (bus.frameStart) starts++;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(negedge pclk);
  endtask
  task automatic clear();
    pq.delete();
    dq.delete();
    starts = 0;
  endtask
  task automatic line(input int n, input int start, input int gap);
    for (int i = 0; i < n; i++) begin
      bus.href = 1'b1;
      bus.camData = 8'(start + i);
      tick();
    end
    bus.href = 1'b0;
    bus.camData = 8'h00;
    tick(gap);
  endtask
  task automatic frame_begin();
    bus.vsync = 1'b0;
    tick(2);
  endtask
  task automatic frame_end();
    bus.vsync = 1'b1;
    tick(4);
  endtask
  task automatic chk_clean(input int b0, input int b1);
    chk("clean_count", pq.size(), 8);
    for (int i = 0; i < 8 && i < pq.size(); i++) begin
      int k = i % 4;
      int b = (i < 4) ? b0 : b1;
      chk("clean_data", pq[i].d, ((b + 2 * k) << 8) | (b + 2 * k + 1));
      chk("clean_x", pq[i].x, k);
      chk("clean_y", pq[i].y, i / 4);
    end
    chk("clean_done", dq.size(), 1);
    if (dq.size() == 1) chk("clean_err", dq[0], 0);
    chk("clean_start", starts, 1);
  endtask
  initial begin
    bus.href = 1'b0;
    bus.vsync = 1'b0;
    bus.camData = 8'h00;
    tick(3);
    chk("reset_outs", {bus.pixelValid, bus.pixelData, bus.pixelX, bus.pixelY,
                       bus.frameStart, bus.frameDone, bus.frameError}, 0);
    reset = 1'b0;
    frame_end();
    // clean frame: bytes 0x01..0x10 over two lines
    clear();
    frame_begin();
    line(8, 8'h01, 3);
    line(8, 8'h09, 3);
    frame_end();
    chk_clean(8'h01, 8'h09);
    // pin-to-output latency of a single pixel; one short line is a bad frame
    clear();
    frame_begin();
    bus.href = 1'b1;
    bus.camData = 8'hA1;
    n0 = cyc + 1;
    tick();
    bus.camData = 8'hB2;
    tick();
    bus.href = 1'b0;
    tick(3);
    chk("lat_count", pq.size(), 1);
    if (pq.size() == 1) begin
      chk("lat_data", pq[0].d, 16'hA1B2);
      chk("lat_cycle", pq[0].c, n0 + 2);
    end
    frame_end();
    chk("lat_done", dq.size(), 1);
    if (dq.size() == 1) chk("lat_err", dq[0], 1);
    // odd byte count on a line
    clear();
    frame_begin();
    line(7, 8'h20, 3);
    line(8, 8'h30, 3);
    frame_end();
    chk("odd_count", pq.size(), 7);
    if (pq.size() == 7) begin
      chk("odd_last_l0", pq[2].d, 16'h2425);
      chk("odd_first_l1", pq[3].d, 16'h3031);
      chk("odd_x_l1", pq[3].x, 0);
      chk("odd_y_l1", pq[3].y, 1);
    end
    chk("odd_done", dq.size(), 1);
    if (dq.size() == 1) chk("odd_err", dq[0], 1);
    // too many lines
    clear();
    frame_begin();
    line(8, 8'h40, 3);
    line(8, 8'h50, 3);
    line(8, 8'h60, 3);
    frame_end();
    chk("vlines_count", pq.size(), 8);
    if (pq.size() == 8) chk("vlines_last", pq[7].d, 16'h5657);
    chk("vlines_done", dq.size(), 1);
    if (dq.size() == 1) chk("vlines_err", dq[0], 1);
    // clean frame whose last href fall coincides with the vsync rise
    clear();
    frame_begin();
    line(8, 8'h70, 3);
    line(8, 8'h78, 0);
    frame_end();
    chk_clean(8'h70, 8'h78);
    // too many pixels on a line
    clear();
    frame_begin();
    line(10, 8'h80, 3);
    line(8, 8'h90, 3);
    frame_end();
    chk("hpix_count", pq.size(), 8);
    if (pq.size() == 8) begin
      chk("hpix_last_l0", pq[3].d, 16'h8687);
      chk("hpix_first_l1", pq[4].d, 16'h9091);
    end
    chk("hpix_done", dq.size(), 1);
    if (dq.size() == 1) chk("hpix_err", dq[0], 1);
    // reset mid-line of line 1 aborts the frame
    clear();
    frame_begin();
    line(8, 8'hA0, 3);
    for (int i = 0; i < 3; i++) begin
      bus.href = 1'b1;
      bus.camData = 8'(8'hB0 + i);
      tick();
    end
    reset = 1'b1;
    tick();
    chk("midreset_outs", {bus.pixelValid, bus.pixelData, bus.pixelX, bus.pixelY,
                          bus.frameStart, bus.frameDone, bus.frameError}, 0);
    reset = 1'b0;
    clear();
    line(4, 8'hB3, 3);
    frame_end();
    chk("midreset_pix", pq.size(), 0);
    chk("midreset_done", dq.size(), 0);
    clear();
    frame_begin();
    line(8, 8'hC0, 3);
    line(8, 8'hC8, 3);
    frame_end();
    chk_clean(8'hC0, 8'hC8);
    // href activity during vertical blanking is ignored
    clear();
    line(8, 8'hD0, 3);
    line(6, 8'hE0, 3);
    chk("vblank_pix", pq.size(), 0);
    chk("vblank_done", dq.size(), 0);
    chk("vblank_start", starts, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
